// File: rtl/branch_resolver.sv
// Two-stage pipelined RV64 branch resolution: S1 registers compare flags and targets, S2 decodes the
// taken/next_pc/mispredict outputs. Optional BRANCH_STATS_EN adds saturating handshake/mispredict counters.
module branch_resolver #(
    parameter int         XLEN       = 64,
    parameter logic [1:0] ALIGN_MASK = 2'b11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            pred_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic [XLEN-1:0] next_pc,
    output logic            mispredict,
    output logic            misaligned,
    output logic            illegal
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    logic            s1_valid_q;
    logic            eq_q, lu_q, ls_q, pred_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] tgt_q, seq_q;

    logic            s2_valid_q;
    logic            taken_q, mispredict_q, misaligned_q, illegal_q;
    logic [XLEN-1:0] next_pc_q;

    logic            s2_adv, accept;
    logic [XLEN:0]   diff;
    logic            eq_d, lu_d, ls_d;
    logic            taken_d, mispredict_d, misaligned_d, illegal_d;
    logic [XLEN-1:0] next_pc_d;

    // Handshake: a transfer happens on a rising edge where valid && ready; flush overrides both sides.
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        in_ready = !flush && (!s1_valid_q || s2_adv);
        accept   = in_valid && in_ready;
        diff     = {1'b0, rs1} + {1'b0, ~rs2} + {{XLEN{1'b0}}, 1'b1};
        eq_d     = (rs1 == rs2);
        lu_d     = ~diff[XLEN];
        ls_d     = (rs1[XLEN-1] == rs2[XLEN-1]) ? lu_d : rs1[XLEN-1];
    end

    always_comb begin
        taken_d      = 1'b0;
        illegal_d    = 1'b0;
        case (f3_q)
            3'b000:  taken_d = eq_q;
            3'b001:  taken_d = !eq_q;
            3'b100:  taken_d = ls_q;
            3'b101:  taken_d = !ls_q;
            3'b110:  taken_d = lu_q;
            3'b111:  taken_d = !lu_q;
            default: illegal_d = 1'b1;
        endcase
        next_pc_d    = taken_d ? tgt_q : seq_q;
        mispredict_d = !illegal_d && (taken_d != pred_q);
        misaligned_d = taken_d && ((tgt_q[1:0] & ALIGN_MASK) != 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            eq_q       <= 1'b0;
            lu_q       <= 1'b0;
            ls_q       <= 1'b0;
            pred_q     <= 1'b0;
            f3_q       <= 3'b000;
            tgt_q      <= '0;
            seq_q      <= '0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            eq_q       <= eq_d;
            lu_q       <= lu_d;
            ls_q       <= ls_d;
            pred_q     <= pred_taken;
            f3_q       <= funct3;
            tgt_q      <= pc + imm;
            seq_q      <= pc + XLEN'(4);
        end else if (s2_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    // S2 payload only moves when advancing, so a stalled result holds stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q   <= 1'b0;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
            next_pc_q    <= '0;
        end else if (flush) begin
            s2_valid_q <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                taken_q      <= taken_d;
                mispredict_q <= mispredict_d;
                misaligned_q <= misaligned_d;
                illegal_q    <= illegal_d;
                next_pc_q    <= next_pc_d;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign taken      = taken_q;
    assign next_pc    = next_pc_q;
    assign mispredict = mispredict_q;
    assign misaligned = misaligned_q;
    assign illegal    = illegal_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_q, stat_mispredicts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else if (s2_valid_q && out_ready) begin
            if (stat_branches_q != 32'hFFFF_FFFF)
                stat_branches_q <= stat_branches_q + 32'd1;
            if (mispredict_q && (stat_mispredicts_q != 32'hFFFF_FFFF))
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed vector table, stall/flush/reset sequences, random traffic vs model.
module tb_branch_resolver;
  localparam int W = 68;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, pred_taken, out_valid, out_ready;
  logic taken, mispredict, misaligned, illegal;
  logic [2:0] funct3;
  logic [63:0] rs1, rs2, pc, imm, next_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_resolver dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm), .pred_taken(pred_taken),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .next_pc(next_pc),
    .mispredict(mispredict), .misaligned(misaligned), .illegal(illegal)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [63:0] a, b, p, i;
    logic        pr;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[12];
  logic [W-1:0] exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  bit hold_prev = 0;
  logic [W:0] hold_snap;

  function automatic logic [W-1:0] pack(input logic t, input logic [63:0] npc,
                                        input logic mp, input logic ma, input logic il);
    return {t, npc, mp, ma, il};
  endfunction

  // reference model: branch rules from the ISA, plain comparisons
  function automatic logic [W-1:0] model(input logic [2:0] f3, input logic [63:0] a, b, p, i,
                                         input logic pr);
    logic [63:0] tgt, seq;
    logic t;
    tgt = p + i;
    seq = p + 64'd4;
    case (f3)
      3'd0: t = (a == b);
      3'd1: t = (a != b);
      3'd4: t = ($signed(a) < $signed(b));
      3'd5: t = ($signed(a) >= $signed(b));
      3'd6: t = (a < b);
      3'd7: t = (a >= b);
      default: return pack(1'b0, seq, 1'b0, 1'b0, 1'b1);
    endcase
    return pack(t, t ? tgt : seq, t != pr, t && (tgt[1:0] != 2'b00), 1'b0);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] cur_out();
    return {taken, next_pc, mispredict, misaligned, illegal};
  endfunction

  // driver: called at a negedge, drives one cycle, records expected result on acceptance
  task automatic drive_cycle(input logic v, input logic [2:0] f3, input logic [63:0] a, b, p, i,
                             input logic pr, input logic [W-1:0] e, output bit acc);
    in_valid = v; funct3 = f3; rs1 = a; rs2 = b; pc = p; imm = i; pred_taken = pr;
    #1;
    acc = v && in_ready && !flush;
    if (acc) exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic send_vec(input int k);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    while (!acc && n < 50) begin
      drive_cycle(1'b1, tbl[k].f3, tbl[k].a, tbl[k].b, tbl[k].p, tbl[k].i, tbl[k].pr, tbl[k].exp, acc);
      n++;
    end
    if (!acc) begin
      total_cnt++;
      $display("FAIL accept_timeout: vector %0d not accepted, expected acceptance", k);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) drive_cycle(1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0, acc);
  endtask

  // scoreboard / monitor: samples mid-low-phase, handshake completes at the following rising edge
  always begin
    @(negedge clk);
    #2;
    if (rst_n && !flush) begin
      if (hold_prev) check("hold_stable", {out_valid, cur_out()}, hold_snap);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_out: got result %h, expected no output", cur_out());
        end else begin
          check("result", cur_out(), exp_q.pop_front());
        end
      end
      hold_prev = out_valid && !out_ready;
      hold_snap = {out_valid, cur_out()};
    end else begin
      hold_prev = 0;
    end
  end

  initial begin
    bit acc;
    logic [63:0] a, b, p, i;
    logic [12:0] bimm;
    logic [2:0] f3;
    logic pr, v;
    int n;

    tbl[0]  = '{3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h1000, 64'h40, 1'b0, pack(1, 64'h1040, 1, 0, 0)};
    tbl[1]  = '{3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h1000, 64'h40, 1'b0, pack(0, 64'h1004, 0, 0, 0)};
    tbl[2]  = '{3'd5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h3000, 64'h100, 1'b1, pack(1, 64'h3100, 0, 0, 0)};
    tbl[3]  = '{3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h3004, 64'h100, 1'b1, pack(0, 64'h3008, 1, 0, 0)};
    tbl[4]  = '{3'd0, 64'd5, 64'd5, 64'h2000, 64'h6, 1'b1, pack(1, 64'h2006, 0, 1, 0)};
    tbl[5]  = '{3'd2, 64'd1, 64'd2, 64'h4000, 64'h8, 1'b1, pack(0, 64'h4004, 0, 0, 1)};
    tbl[6]  = '{3'd3, 64'd9, 64'd9, 64'h5000, 64'h20, 1'b0, pack(0, 64'h5004, 0, 0, 1)};
    tbl[7]  = '{3'd7, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h6000, 64'hFFFF_FFFF_FFFF_FFE0, 1'b1, pack(0, 64'h6004, 1, 0, 0)};
    tbl[8]  = '{3'd4, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h7000, 64'h10, 1'b0, pack(0, 64'h7004, 0, 0, 0)};
    tbl[9]  = '{3'd6, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h7000, 64'h10, 1'b0, pack(1, 64'h7010, 1, 0, 0)};
    tbl[10] = '{3'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 1'b1, pack(1, 64'h4, 0, 0, 0)};
    tbl[11] = '{3'd1, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 1'b0, pack(0, 64'h0, 0, 0, 0)};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    funct3 = '0; rs1 = '0; rs2 = '0; pc = '0; imm = '0; pred_taken = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {out_valid, cur_out()}, '0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", in_ready, 1);
    @(negedge clk);

    // latency: accepted at one edge, visible after the second
    drive_cycle(1'b1, tbl[0].f3, tbl[0].a, tbl[0].b, tbl[0].p, tbl[0].i, tbl[0].pr, tbl[0].exp, acc);
    in_valid = 1'b0;
    check("latency_accept", acc, 1);
    check("latency_s1", out_valid, 0);
    @(negedge clk);
    check("latency_s2", out_valid, 1);
    idle(3);

    // directed table, back-to-back with out_ready high
    for (int k = 0; k < 12; k++) send_vec(k);
    idle(4);
    check("drain_table", exp_q.size(), 0);

    // back-pressure then flush
    out_ready = 1'b0;
    send_vec(0);
    send_vec(4);
    drive_cycle(1'b1, tbl[1].f3, tbl[1].a, tbl[1].b, tbl[1].p, tbl[1].i, tbl[1].pr, tbl[1].exp, acc);
    check("stall_third_rejected", acc, 0);
    drive_cycle(1'b1, tbl[1].f3, tbl[1].a, tbl[1].b, tbl[1].p, tbl[1].i, tbl[1].pr, tbl[1].exp, acc);
    check("stall_still_rejected", acc, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_head_result", cur_out(), tbl[0].exp);
    flush = 1'b1;
    in_valid = 1'b1;
    #1;
    check("flush_in_ready_low", in_ready, 0);
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready_back", in_ready, 1);
    out_ready = 1'b1;
    @(negedge clk);
    idle(6);

    // random traffic with random back-pressure
    for (int k = 0; k < 400; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 3) != 0);
      f3 = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = {a[63], 63'($urandom)};
        default: b = {$urandom, $urandom};
      endcase
      p = {$urandom, $urandom} & ~64'h3;
      bimm = 13'($urandom);
      bimm[0] = 1'b0;
      i = {{51{bimm[12]}}, bimm};
      pr = 1'($urandom_range(0, 1));
      drive_cycle(v, f3, a, b, p, i, pr, model(f3, a, b, p, i, pr), acc);
    end
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    check("drain_random", exp_q.size(), 0);

    // asynchronous reset mid-operation
    send_vec(2);
    send_vec(3);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {out_valid, cur_out()}, '0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);

`ifdef BRANCH_STATS_EN
    for (int k = 0; k < 10; k++) send_vec((k == 9) ? 10 : k);
    idle(4);
    check("stat_branches", stat_branches, 10);
    check("stat_mispredicts", stat_mispredicts, 3);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Two-stage pipelined branch resolution unit for the RV64 integer core.
- Consumes the operand pair and the branch funct3 from issue. Derives equal, signed-less and unsigned-less flags from an internal 64-bit subtraction rs1 - rs2.
- Decides taken/not-taken, computes the next PC and flags mispredicts against the front-end prediction.
- Valid/ready handshakes on both sides; sits between issue and the fetch redirect logic.

Parameters:
- XLEN, 64, operand and PC width.
- ALIGN_MASK, 2'b11, low target bits that must be zero for a taken branch (no C extension).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill every in-flight branch; sampled on the clk edge.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- funct3  in  3  branch type.
- rs1  in  XLEN  first operand.
- rs2  in  XLEN  second operand.
- pc  in  XLEN  branch PC.
- imm  in  XLEN  sign-extended B-immediate.
- pred_taken  in  1  front-end prediction.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- taken  out  1  branch taken.
- next_pc  out  XLEN  taken ? pc+imm : pc+4.
- mispredict  out  1  taken != pred_taken.
- misaligned  out  1  taken and (pc+imm) & ALIGN_MASK != 0.
- illegal  out  1  funct3 is 010 or 011.

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0. All outputs are 0, including next_pc=0. in_ready=1 once rst_n is high.
- S1 capture on in_valid && in_ready:
  - eq = (rs1 == rs2).
  - lu = borrow of rs1 - rs2, i.e. the carry-out of rs1 + ~rs2 + 1 inverted.
  - ls = lu when rs1[63] == rs2[63], otherwise rs1[63].
  - Also registers funct3, pred_taken, tgt = pc+imm, seq = pc+4. Both additions wrap modulo 2^XLEN.
- S2 decode from the S1 flags:
  - 000 BEQ: eq.
  - 001 BNE: !eq.
  - 100 BLT: ls.
  - 101 BGE: !ls.
  - 110 BLTU: lu.
  - 111 BGEU: !lu.
  - 010, 011: taken=0, illegal=1, mispredict=0, misaligned=0, next_pc=seq.
- All S2 outputs are registered. Latency is 2 cycles from input acceptance to out_valid when out_ready is held high. Throughput is 1 per cycle.
- Stall rules:
  - S2 advances when !s2_valid || out_ready.
  - S1 advances into S2 under the same condition.
  - in_ready = !s1_valid || s2_advance.
  - No combinational path from in_valid to out_valid.
- While out_valid=1 && out_ready=0, all S2 outputs hold stable.
- flush:
  - Clears s1_valid and s2_valid at the edge.
  - A request presented in the same cycle as flush is dropped.
  - in_ready is forced to 0 during a flush cycle.
  - flush takes priority over every other event.
- Reset mid-operation drops all in-flight branches immediately; no output pulse.

Optional Feature:
- BRANCH_STATS_EN defined:
  - Adds outputs stat_branches (32 bits) and stat_mispredicts (32 bits).
  - stat_branches increments on each out_valid && out_ready handshake.
  - stat_mispredicts increments on each such handshake where mispredict=1.
  - Both counters saturate at 0xFFFFFFFF, are unaffected by flush, and clear on rst_n.
- Undefined: these ports and counters do not exist.

Test Plan:
- BLT rs1=0xFFFFFFFFFFFFFFFF (-1), rs2=1, pc=0x1000, imm=0x40, pred_taken=0, out_ready=1 -> 2 cycles later out_valid=1, taken=1, next_pc=0x1040, mispredict=1.
- BLTU with the same operands -> taken=0, next_pc=0x1004, mispredict=0.
- BGE rs1=rs2=0x8000000000000000, then BNE with the same operands back-to-back -> taken=1 then taken=0 on consecutive cycles, out_valid high 2 cycles.
- BEQ rs1=rs2=5, pc=0x2000, imm=0x6 -> taken=1, misaligned=1, next_pc=0x2006.
- funct3=010 -> illegal=1, taken=0, next_pc=pc+4.
- Back-pressure and flush:
  - out_ready=0 while sending 3 requests -> in_ready drops after 2 accepted; outputs hold.
  - Then assert flush -> out_valid=0 next cycle, in_ready=1, no stale result ever emitted.
- BRANCH_STATS_EN defined: 10 handshakes with 3 mispredicts -> stat_branches=10, stat_mispredicts=3.
